// File: rtl/tt_chk_pkg.sv
// Shared types and constants for the truth-table response checker.
// The FSM state enum, vector geometry and the MISR polynomial/seed live here
// so the checker, its signature sub-block and the bench agree on them.
package tt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int          VEC_W     = 4;
  localparam int          N_MIN     = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One MISR step: shift left, fold in the polynomial on carry-out, xor the sample.
  function automatic logic [15:0] misr_next(input logic [15:0] cur,
                                            input logic [VEC_W:0] din);
    logic [15:0] nxt;
    nxt = {cur[14:0], 1'b0};
    if (cur[15]) nxt = nxt ^ MISR_POLY;
    nxt = nxt ^ {{(15 - VEC_W){1'b0}}, din};
    return nxt;
  endfunction

endpackage

// File: rtl/tt_response_checker_if.sv
// Sample and result bundle between a stimulus/observer (master) and the
// truth-table response checker (slave).
// Handshake: there is no back-pressure. A sample {vec,o} is consumed on every
// rising clock edge where vld is high and the checker is in COLLECT; start is
// a single-cycle request honoured only from IDLE or DONE. Results (pass,
// tables, counters, sig) are stable whenever done is high.
interface tt_response_checker_if;
  import tt_chk_pkg::*;

  logic             start;
  logic             vld;
  logic [VEC_W-1:0] vec;
  logic             o;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic             conflict;
  logic [N_MIN-1:0] seen_tt;
  logic [N_MIN-1:0] obs_tt;
  logic [4:0]       mismatch_cnt;
  logic [VEC_W-1:0] first_err_vec;
  logic [15:0]      sig;

  modport master (
    output start, vld, vec, o,
    input  busy, done, pass, timeout, conflict, seen_tt, obs_tt,
           mismatch_cnt, first_err_vec, sig
  );

  modport slave (
    input  start, vld, vec, o,
    output busy, done, pass, timeout, conflict, seen_tt, obs_tt,
           mismatch_cnt, first_err_vec, sig
  );

endinterface

// File: rtl/tt_chk_misr.sv
// 16-bit multiple-input signature register over accepted {vec,o} samples.
// clr reseeds for a new run and takes priority over en; the value holds
// whenever neither is asserted.
module tt_chk_misr
  import tt_chk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [VEC_W:0]   din,
  output logic [15:0]      sig
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  // Next signature: reseed, step, or hold.
  always_comb begin
    sig_d = sig_q;
    if (clr)     sig_d = MISR_SEED;
    else if (en) sig_d = misr_next(sig_q, din);
  end

  // Signature register, zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 16'h0000;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/tt_response_checker.sv
// Truth-table response checker for a 4-input combinational block.
// Collects {vec,o} samples, builds coverage and observed tables, counts
// first-seen mismatches against EXP_TT, flags conflicting repeats and
// reports pass/fail once all 16 minterms are seen or TIMEOUT cycles elapse.
// Optional: define TT_CHK_SIGNATURE_EN to add the MISR signature on sig;
// otherwise sig is tied to zero.
module tt_response_checker
  import tt_chk_pkg::*;
#(
  parameter logic [15:0] EXP_TT  = 16'h0000,
  parameter int          TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  tt_response_checker_if.slave  bus,
  output state_e                state_o
);

  localparam int             TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [N_MIN-1:0] seen_q, seen_d;
  logic [N_MIN-1:0] obs_q, obs_d;
  logic [4:0]       mism_q, mism_d;
  logic [VEC_W-1:0] first_q, first_d;
  logic             conf_q, conf_d;
  logic             tmo_q, tmo_d;
  logic             pass_q, pass_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             timeout_hit;
  logic             exp_bit;
  logic [15:0]      sig_w;

  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMAX);
  assign exp_bit     = EXP_TT[bus.vec];

  // FSM and datapath next state; a run start clears all per-run results.
  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    obs_d   = obs_q;
    mism_d  = mism_q;
    first_d = first_q;
    conf_d  = conf_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;
    timer_d = timer_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = COLLECT;
          seen_d  = '0;
          obs_d   = '0;
          mism_d  = '0;
          first_d = '0;
          conf_d  = 1'b0;
          tmo_d   = 1'b0;
          pass_d  = 1'b0;
          timer_d = '0;
        end
      end
      COLLECT: begin
        timer_d = timer_q + TW'(1);
        if (bus.vld) begin
          if (!seen_q[bus.vec]) begin
            seen_d[bus.vec] = 1'b1;
            obs_d[bus.vec]  = bus.o;
            if (bus.o != exp_bit) begin
              if (mism_q == 5'd0) first_d = bus.vec;
              if (mism_q != 5'(N_MIN)) mism_d = mism_q + 5'd1;
            end
          end else if (obs_q[bus.vec] != bus.o) begin
            conf_d = 1'b1;
          end
        end
        // Coverage includes this cycle's sample and beats a coincident timeout.
        if (&seen_d) begin
          state_d = CHECK;
        end else if (timeout_hit) begin
          tmo_d   = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        pass_d  = (mism_q == 5'd0) && !conf_q && !tmo_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      seen_q  <= '0;
      obs_q   <= '0;
      mism_q  <= '0;
      first_q <= '0;
      conf_q  <= 1'b0;
      tmo_q   <= 1'b0;
      pass_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      obs_q   <= obs_d;
      mism_q  <= mism_d;
      first_q <= first_d;
      conf_q  <= conf_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
      timer_q <= timer_d;
    end
  end

`ifdef TT_CHK_SIGNATURE_EN
  logic misr_clr;
  logic misr_en;

  assign misr_clr = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign misr_en  = bus.vld && (state_q == COLLECT);

  tt_chk_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .din ({bus.vec, bus.o}),
    .sig (sig_w)
  );
`else
  assign sig_w = 16'h0000;
`endif

  assign bus.busy          = (state_q == COLLECT) || (state_q == CHECK);
  assign bus.done          = (state_q == DONE);
  assign bus.pass          = pass_q;
  assign bus.timeout       = tmo_q;
  assign bus.conflict      = conf_q;
  assign bus.seen_tt       = seen_q;
  assign bus.obs_tt        = obs_q;
  assign bus.mismatch_cnt  = mism_q;
  assign bus.first_err_vec = first_q;
  assign bus.sig           = sig_w;
  assign state_o           = state_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: directed runs push expected results into a
// queue, a monitor pops and compares when done rises.
module tb_tt_response_checker;
  import tt_chk_pkg::*;

  localparam logic [15:0] EXP = 16'hB4E1;
  localparam int          TMO = 32;

  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic        conflict;
    logic [15:0] seen;
    logic [15:0] obs;
    logic [4:0]  mism;
    logic [3:0]  first;
    logic [15:0] sig;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  state_e state;
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;

  exp_t   exp_q[$];
  int     exp_cyc_q[$];
  string  name_q[$];

  int          start_cyc;
  int          last_cyc;
  logic [15:0] m_sig;
  logic [15:0] last_sig;
  logic [15:0] sig_fwd;
  logic [15:0] sig_rev;
  logic        done_prev = 1'b0;

  tt_response_checker_if tif ();

  tt_response_checker #(.EXP_TT(EXP), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (tif),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [3:0] v,
                                           input logic b);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    n = n ^ {11'b0, v, b};
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run();
    tif.start = 1'b1;
    start_cyc = cyc;
    m_sig     = 16'hFFFF;
    step();
    tif.start = 1'b0;
  endtask

  task automatic send(input logic [3:0] v, input logic b);
    tif.vld  = 1'b1;
    tif.vec  = v;
    tif.o    = b;
    last_cyc = cyc;
    m_sig    = misr_ref(m_sig, v, b);
    step();
    tif.vld  = 1'b0;
  endtask

  task automatic sweep(input logic [15:0] flip, input bit rev);
    logic [15:0] e;
    logic [3:0]  v;
    e = EXP;
    for (int i = 0; i < 16; i++) begin
      v = rev ? 4'(15 - i) : 4'(i);
      send(v, e[v] ^ flip[v]);
    end
  endtask

  task automatic push_exp(input string nm, input logic p, input logic t, input logic c,
                          input logic [15:0] seen, input logic [15:0] obs,
                          input logic [4:0] mism, input logic [3:0] first, input int dcyc);
    exp_t e;
    e.pass = p; e.timeout = t; e.conflict = c; e.seen = seen; e.obs = obs;
    e.mism = mism; e.first = first;
`ifdef TT_CHK_SIGNATURE_EN
    e.sig = m_sig;
`else
    e.sig = 16'h0000;
`endif
    exp_q.push_back(e);
    exp_cyc_q.push_back(dcyc);
    name_q.push_back(nm);
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    chk({nm, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
    name_q.delete();
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_state"},    state,             IDLE);
    chk({nm, "_busy"},     tif.busy,          0);
    chk({nm, "_done"},     tif.done,          0);
    chk({nm, "_pass"},     tif.pass,          0);
    chk({nm, "_timeout"},  tif.timeout,       0);
    chk({nm, "_conflict"}, tif.conflict,      0);
    chk({nm, "_seen"},     tif.seen_tt,       0);
    chk({nm, "_obs"},      tif.obs_tt,        0);
    chk({nm, "_mism"},     tif.mismatch_cnt,  0);
    chk({nm, "_first"},    tif.first_err_vec, 0);
    chk({nm, "_sig"},      tif.sig,           0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t  e;
    int    dc;
    string nm;
    forever begin
      @(negedge clk);
      if (tif.done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e  = exp_q.pop_front();
          dc = exp_cyc_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, "_done_cyc"}, cyc,               dc);
          chk({nm, "_busy"},     tif.busy,          0);
          chk({nm, "_pass"},     tif.pass,          e.pass);
          chk({nm, "_timeout"},  tif.timeout,       e.timeout);
          chk({nm, "_conflict"}, tif.conflict,      e.conflict);
          chk({nm, "_seen"},     tif.seen_tt,       e.seen);
          chk({nm, "_obs"},      tif.obs_tt,        e.obs);
          chk({nm, "_mism"},     tif.mismatch_cnt,  e.mism);
          chk({nm, "_first"},    tif.first_err_vec, e.first);
          chk({nm, "_sig"},      tif.sig,           e.sig);
          last_sig = tif.sig;
        end
      end
      done_prev = tif.done;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] e;
    e = EXP;
    rst = 1'b1;
    tif.start = 1'b0; tif.vld = 1'b0; tif.vec = 4'h0; tif.o = 1'b0;
    m_sig = 16'hFFFF; last_sig = 16'h0; sig_fwd = 16'h0; sig_rev = 16'h0;
    step(); step();
    chk_idle_zero("reset");
    rst = 1'b0;
    step();

    // 1: clean forward sweep
    begin_run();
    sweep(16'h0000, 1'b0);
    push_exp("t1_clean", 1, 0, 0, 16'hFFFF, 16'hB4E1, 5'd0, 4'd0, last_cyc + 2);
    wait_drain("t1");
    sig_fwd = last_sig;

    // 2: vec 5 and 9 inverted; a stray start mid-collect must be ignored
    begin_run();
    for (int i = 0; i < 16; i++) begin
      tif.start = (i == 8);
      send(4'(i), e[i] ^ ((i == 5) || (i == 9)));
    end
    tif.start = 1'b0;
    push_exp("t2_mism", 0, 0, 0, 16'hFFFF, 16'hB6C1, 5'd2, 4'd5, last_cyc + 2);
    wait_drain("t2");

    // 3: conflicting repeat on vec 3 (first sample o=1 is also a mismatch)
    begin_run();
    send(4'd3, 1'b1);
    send(4'd3, 1'b0);
    for (int i = 0; i < 16; i++) if (i != 3) send(4'(i), e[i]);
    push_exp("t3_conflict", 0, 0, 1, 16'hFFFF, 16'hB4E9, 5'd1, 4'd3, last_cyc + 2);
    wait_drain("t3");

    // 4: partial coverage, run ends by timeout
    begin_run();
    for (int i = 0; i < 8; i++) send(4'(i), e[i]);
    push_exp("t4_timeout", 0, 1, 0, 16'h00FF, 16'h00E1, 5'd0, 4'd0, start_cyc + 34);
    wait_drain("t4");

    // 5: reset mid-run, vld ignored until start, then a fresh run passes
    begin_run();
    for (int i = 0; i < 6; i++) send(4'(i), e[i]);
    rst = 1'b1;
    #1;
    chk_idle_zero("t5_rst");
    step();
    rst = 1'b0;
    send(4'd0, 1'b1);
    send(4'd1, 1'b0);
    chk("t5_ignored_seen", tif.seen_tt, 0);
    chk("t5_ignored_state", state, IDLE);
    chk("t5_ignored_busy", tif.busy, 0);
    begin_run();
    sweep(16'h0000, 1'b0);
    push_exp("t5_fresh", 1, 0, 0, 16'hFFFF, 16'hB4E1, 5'd0, 4'd0, last_cyc + 2);
    wait_drain("t5");

    // 6: reverse order sweep
    begin_run();
    sweep(16'h0000, 1'b1);
    push_exp("t6_reverse", 1, 0, 0, 16'hFFFF, 16'hB4E1, 5'd0, 4'd0, last_cyc + 2);
    wait_drain("t6");
    sig_rev = last_sig;
`ifdef TT_CHK_SIGNATURE_EN
    chk("t6_sig_order_differs", (sig_fwd != sig_rev), 1);
`endif

    // 7: every sample wrong, mismatch counter reaches its ceiling of 16
    begin_run();
    sweep(16'hFFFF, 1'b0);
    push_exp("t7_all_bad", 0, 0, 0, 16'hFFFF, 16'h4B1E, 5'd16, 4'd0, last_cyc + 2);
    wait_drain("t7");

    // results hold in DONE
    step(); step();
    chk("hold_done", tif.done, 1);
    chk("hold_mism", tif.mismatch_cnt, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
